axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator that turns a simple command/response handshake into AW/W/B or AR/R channel traffic.
- Drives the slave side of the DPRAM AXI-Lite bridge from local control logic, such as a test sequencer or config loader.
- Issues exactly one transaction at a time and returns read data plus the response code to the requester.

Parameters:
- axi_addr_width, 32, AXI address width; passed through unmodified.
- axi_data_width, 32, AXI data width; strobe width is axi_data_width/8. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  axi_addr_width  byte address
- cmd_wdata  in  axi_data_width  write data
- cmd_wstrb  in  axi_data_width/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  axi_data_width  read data; 0 for writes
- rsp_resp  out  2  captured BRESP/RRESP
- rsp_err  out  1  rsp_resp != 2'b00
- axi_awaddr  out  axi_addr_width
- axi_awvalid  out  1
- axi_awready  in  1
- axi_wdata  out  axi_data_width
- axi_wstrb  out  axi_data_width/8
- axi_wvalid  out  1
- axi_wready  in  1
- axi_bresp  in  2
- axi_bvalid  in  1
- axi_bready  out  1
- axi_araddr  out  axi_addr_width
- axi_arvalid  out  1
- axi_arready  in  1
- axi_rdata  in  axi_data_width
- axi_rresp  in  2
- axi_rvalid  in  1
- axi_rready  out  1

Behaviour:
- All outputs are registered except cmd_ready, which is (state==IDLE).
- Reset (rst=0 at posedge) values: all valid/ready outputs 0, rsp_rdata 0, rsp_resp 0, rsp_err 0, axi_awaddr/araddr/wdata/wstrb 0, state IDLE.
- Reset mid-transaction abandons the transaction at the next edge; the slave shares rst.
- States are IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - On cmd_valid at posedge, latch addr/wdata/wstrb.
  - Write: axi_awvalid=1, axi_wvalid=1, go to WR.
  - Read: axi_arvalid=1, go to RD_ADDR.
  - Valids are therefore high starting the cycle after command acceptance.
- WR:
  - axi_awvalid drops at the posedge where awvalid&&awready; axi_wvalid drops at the posedge where wvalid&&wready. The two are independent, in either order or the same cycle.
  - Internal aw_done/w_done flags record each handshake.
  - When both handshakes are complete (including the edge that completes the last one), set axi_bready=1 and go to WR_RESP.
  - A valid is never deasserted before its handshake and payload never changes while valid is high.
- WR_RESP:
  - On bvalid&&bready: capture rsp_resp=bresp, rsp_err, rsp_rdata=0; clear axi_bready; set rsp_valid=1; go to RSP.
  - An axi_bvalid arriving before both AW/W handshakes complete is ignored, since bready=0.
- RD_ADDR: on arvalid&&arready, clear axi_arvalid, set axi_rready=1, go to RD_DATA.
- RD_DATA: on rvalid&&rready, capture rsp_rdata=rdata, rsp_resp=rresp, rsp_err; clear axi_rready; set rsp_valid=1; go to RSP.
- RSP:
  - Hold rsp_* stable while rsp_valid=1.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - The next command can be accepted on the cycle after the rsp handshake. cmd_ready=0 throughout RSP.
- Minimum latency with an always-ready slave:
  - Write: cmd accept edge N, AW/W handshake edge N+1, B edge N+2, rsp_valid visible after N+2.
  - Read: AR handshake edge N+1, R edge N+2.
- No timeout: a slave that never responds stalls the block until reset.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Write 0x0000_0010, data 0xA1B2C3D4, strb 0xF, slave ready in the same cycle, bresp=00 -> AW/W valid one cycle each, rsp_valid two cycles after the accept edge, rsp_resp=00, rsp_err=0, rsp_rdata=0.
- Write with wready asserted 2 cycles before awready -> wvalid drops first, awvalid held with awaddr stable until its handshake, bready rises only after both handshakes, single rsp.
- Read 0x10, arready delayed 3 cycles, rvalid delayed 4 cycles, rdata 0xA1B2C3D4 -> arvalid held 4 cycles, rready held until rvalid, rsp_rdata=0xA1B2C3D4.
- Read with rresp=2'b10 -> rsp_resp=10, rsp_err=1.
- rsp_ready held low 5 cycles, with cmd_valid high and new cmd fields -> rsp_* stable, cmd_ready=0, no new AXI activity; after the rsp handshake the new command is accepted next cycle.
- rst=0 while in WR with awvalid/wvalid high -> the next edge gives all outputs at reset values, state IDLE, cmd_ready=1 after rst releases.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// Command/response and AXI4-Lite channel bundle for axi_lite_master.
// The master modport is the initiator's view; slave is the requester/AXI-slave side.
interface axi_lite_master_if #(
   parameter int unsigned axi_addr_width = 32,
   parameter int unsigned axi_data_width = 32
);
   localparam int unsigned strb_width = axi_data_width / 8;

   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_we;
   logic [axi_addr_width-1:0] cmd_addr;
   logic [axi_data_width-1:0] cmd_wdata;
   logic [strb_width-1:0]     cmd_wstrb;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [axi_data_width-1:0] rsp_rdata;
   logic [1:0]                rsp_resp;
   logic                      rsp_err;

   logic [axi_addr_width-1:0] axi_awaddr;
   logic                      axi_awvalid;
   logic                      axi_awready;
   logic [axi_data_width-1:0] axi_wdata;
   logic [strb_width-1:0]     axi_wstrb;
   logic                      axi_wvalid;
   logic                      axi_wready;
   logic [1:0]                axi_bresp;
   logic                      axi_bvalid;
   logic                      axi_bready;
   logic [axi_addr_width-1:0] axi_araddr;
   logic                      axi_arvalid;
   logic                      axi_arready;
   logic [axi_data_width-1:0] axi_rdata;
   logic [1:0]                axi_rresp;
   logic                      axi_rvalid;
   logic                      axi_rready;

   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      output axi_araddr, axi_arvalid, axi_rready
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      input  axi_araddr, axi_arvalid, axi_rready
   );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AW/W/B or AR/R
// transaction out, one response back. All outputs registered except cmd_ready.
module axi_lite_master #(
   parameter int unsigned axi_addr_width = 32,
   parameter int unsigned axi_data_width = 32
) (
   input logic              clk,
   input logic              rst,
   axi_lite_master_if.master bus
);
   localparam int unsigned strb_width = axi_data_width / 8;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR      = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RSP     = 3'd5;

   logic [2:0]                state, state_n;
   logic                      aw_done, aw_done_n;
   logic                      w_done, w_done_n;
   logic [axi_addr_width-1:0] awaddr, awaddr_n;
   logic                      awvalid, awvalid_n;
   logic [axi_data_width-1:0] wdata, wdata_n;
   logic [strb_width-1:0]     wstrb, wstrb_n;
   logic                      wvalid, wvalid_n;
   logic                      bready, bready_n;
   logic [axi_addr_width-1:0] araddr, araddr_n;
   logic                      arvalid, arvalid_n;
   logic                      rready, rready_n;
   logic                      rsp_valid, rsp_valid_n;
   logic [axi_data_width-1:0] rsp_rdata, rsp_rdata_n;
   logic [1:0]                rsp_resp, rsp_resp_n;
   logic                      rsp_err, rsp_err_n;

   logic aw_hs, w_hs;
   assign aw_hs = awvalid && bus.axi_awready;
   assign w_hs  = wvalid && bus.axi_wready;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         awaddr    <= '0;
         awvalid   <= 1'b0;
         wdata     <= '0;
         wstrb     <= '0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         araddr    <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         aw_done   <= aw_done_n;
         w_done    <= w_done_n;
         awaddr    <= awaddr_n;
         awvalid   <= awvalid_n;
         wdata     <= wdata_n;
         wstrb     <= wstrb_n;
         wvalid    <= wvalid_n;
         bready    <= bready_n;
         araddr    <= araddr_n;
         arvalid   <= arvalid_n;
         rready    <= rready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_resp  <= rsp_resp_n;
         rsp_err   <= rsp_err_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      aw_done_n   = aw_done;
      w_done_n    = w_done;
      awaddr_n    = awaddr;
      awvalid_n   = awvalid;
      wdata_n     = wdata;
      wstrb_n     = wstrb;
      wvalid_n    = wvalid;
      bready_n    = bready;
      araddr_n    = araddr;
      arvalid_n   = arvalid;
      rready_n    = rready;
      rsp_valid_n = rsp_valid;
      rsp_rdata_n = rsp_rdata;
      rsp_resp_n  = rsp_resp;
      rsp_err_n   = rsp_err;

      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_we) begin
                  awaddr_n  = bus.cmd_addr;
                  wdata_n   = bus.cmd_wdata;
                  wstrb_n   = bus.cmd_wstrb;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  aw_done_n = 1'b0;
                  w_done_n  = 1'b0;
                  state_n   = WR;
               end else begin
                  araddr_n  = bus.cmd_addr;
                  arvalid_n = 1'b1;
                  state_n   = RD_ADDR;
               end
            end
         end
         WR: begin
            // AW and W complete independently; B is accepted once both are done
            if (aw_hs) begin
               awvalid_n = 1'b0;
               aw_done_n = 1'b1;
            end
            if (w_hs) begin
               wvalid_n = 1'b0;
               w_done_n = 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               bready_n = 1'b1;
               state_n  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bus.axi_bvalid && bready) begin
               rsp_resp_n  = bus.axi_bresp;
               rsp_err_n   = (bus.axi_bresp != 2'b00);
               rsp_rdata_n = '0;
               bready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = RSP;
            end
         end
         RD_ADDR: begin
            if (arvalid && bus.axi_arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.axi_rvalid && rready) begin
               rsp_rdata_n = bus.axi_rdata;
               rsp_resp_n  = bus.axi_rresp;
               rsp_err_n   = (bus.axi_rresp != 2'b00);
               rready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = RSP;
            end
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.cmd_ready   = (state == IDLE);
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_rdata   = rsp_rdata;
   assign bus.rsp_resp    = rsp_resp;
   assign bus.rsp_err     = rsp_err;
   assign bus.axi_awaddr  = awaddr;
   assign bus.axi_awvalid = awvalid;
   assign bus.axi_wdata   = wdata;
   assign bus.axi_wstrb   = wstrb;
   assign bus.axi_wvalid  = wvalid;
   assign bus.axi_bready  = bready;
   assign bus.axi_araddr  = araddr;
   assign bus.axi_arvalid = arvalid;
   assign bus.axi_rready  = rready;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed self-checking bench for axi_lite_master; the bench plays both the
// requester and the AXI-Lite slave.
module tb_axi_lite_master;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   axi_lite_master_if #(.axi_addr_width(32), .axi_data_width(32)) bus ();

   axi_lite_master #(.axi_addr_width(32), .axi_data_width(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; observe and drive 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = we;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = data;
      bus.cmd_wstrb = strb;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
           bus.rsp_valid, bus.rsp_err} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000000", {bus.axi_awvalid, bus.axi_wvalid,
                  bus.axi_bready, bus.axi_arvalid, bus.axi_rready, bus.rsp_valid, bus.rsp_err});
      end
      checks++;
      if ({bus.axi_awaddr, bus.axi_araddr, bus.axi_wdata, bus.axi_wstrb, bus.rsp_rdata,
           bus.rsp_resp} !== 134'b0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {bus.axi_awaddr, bus.axi_araddr,
                  bus.axi_wdata, bus.axi_wstrb, bus.rsp_rdata, bus.rsp_resp});
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
      end
   endtask

   task automatic test_read_delayed();
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if (bus.axi_araddr !== 32'h0000_0010) begin
         failures++;
         $display("FAIL rd_araddr got=%h exp=00000010", bus.axi_araddr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.axi_arvalid, bus.axi_rready, bus.cmd_ready} !== 3'b100) begin
            failures++;
            $display("FAIL rd_ar_hold%0d got=%b exp=100", i,
                     {bus.axi_arvalid, bus.axi_rready, bus.cmd_ready});
         end
         if (i == 3) bus.axi_arready = 1'b1;
         tick();
      end
      bus.axi_arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.axi_arvalid, bus.axi_rready, bus.rsp_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rd_r_hold%0d got=%b exp=010", i,
                     {bus.axi_arvalid, bus.axi_rready, bus.rsp_valid});
         end
         if (i == 3) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = 32'hA1B2_C3D4;
            bus.axi_rresp  = 2'b00;
         end
         tick();
      end
      bus.axi_rvalid = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.axi_rready, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}
          !== {2'b10, 32'hA1B2_C3D4, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL rd_rsp got=%b_%h_%b_%b exp=10_a1b2c3d4_00_0",
                  {bus.rsp_valid, bus.axi_rready}, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL rd_rsp_done got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_write_basic();
      bus.axi_awready = 1'b1;
      bus.axi_wready  = 1'b1;
      issue(1'b1, 32'h0000_0010, 32'hA1B2_C3D4, 4'hF);
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready, bus.axi_awaddr, bus.axi_wdata,
           bus.axi_wstrb} !== {3'b110, 32'h0000_0010, 32'hA1B2_C3D4, 4'hF}) begin
         failures++;
         $display("FAIL wr_issue got=%b_%h_%h_%h exp=110_00000010_a1b2c3d4_f",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready}, bus.axi_awaddr,
                  bus.axi_wdata, bus.axi_wstrb);
      end
      tick();
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.rsp_valid} !== 4'b0010) begin
         failures++;
         $display("FAIL wr_hs got=%b exp=0010",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.rsp_valid});
      end
      bus.axi_bvalid = 1'b1;
      bus.axi_bresp  = 2'b00;
      tick();
      bus.axi_bvalid = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.axi_bready, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}
          !== {2'b10, 32'h0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL wr_rsp got=%b_%h_%b_%b exp=10_00000000_00_0",
                  {bus.rsp_valid, bus.axi_bready}, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL wr_rsp_done got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_write_w_first();
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b1;
      issue(1'b1, 32'h0000_0024, 32'h1122_3344, 4'h5);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      bus.axi_wready = 1'b0;
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_awaddr}
          !== {3'b100, 32'h0000_0024}) begin
         failures++;
         $display("FAIL wf_w_done got=%b_%h exp=100_00000024",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready}, bus.axi_awaddr);
      end
      // Early B must be ignored until both address and data handshakes finish
      bus.axi_bvalid = 1'b1;
      bus.axi_bresp  = 2'b01;
      tick();
      checks++;
      if ({bus.axi_awvalid, bus.axi_bready, bus.rsp_valid, bus.axi_awaddr}
          !== {3'b100, 32'h0000_0024}) begin
         failures++;
         $display("FAIL wf_aw_hold got=%b_%h exp=100_00000024",
                  {bus.axi_awvalid, bus.axi_bready, bus.rsp_valid}, bus.axi_awaddr);
      end
      bus.axi_awready = 1'b1;
      tick();
      bus.axi_awready = 1'b0;
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.rsp_valid} !== 4'b0010) begin
         failures++;
         $display("FAIL wf_both_done got=%b exp=0010",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.rsp_valid});
      end
      tick();
      bus.axi_bvalid = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.axi_bready, bus.rsp_resp, bus.rsp_err} !== 5'b10011) begin
         failures++;
         $display("FAIL wf_rsp got=%b exp=10011",
                  {bus.rsp_valid, bus.axi_bready, bus.rsp_resp, bus.rsp_err});
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL wf_single_rsp got=%b exp=0001",
                  {bus.rsp_valid, bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready});
      end
   endtask

   task automatic test_read_err();
      bus.axi_arready = 1'b1;
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b1;
      bus.axi_rdata   = 32'hDEAD_BEEF;
      bus.axi_rresp   = 2'b10;
      tick();
      bus.axi_rvalid = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}
          !== {1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1}) begin
         failures++;
         $display("FAIL rderr_rsp got=%b_%h_%b_%b exp=1_deadbeef_10_1",
                  bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_rsp_stall();
      bus.axi_awready = 1'b1;
      bus.axi_wready  = 1'b1;
      issue(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bvalid  = 1'b1;
      bus.axi_bresp   = 2'b00;
      tick();
      bus.axi_bvalid = 1'b0;
      issue(1'b0, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.rsp_valid, bus.cmd_ready, bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid,
              bus.rsp_rdata, bus.rsp_resp, bus.rsp_err} !== {5'b10000, 32'h0, 3'b000}) begin
            failures++;
            $display("FAIL stall%0d got=%b_%h_%b exp=10000_00000000_000", i,
                     {bus.rsp_valid, bus.cmd_ready, bus.axi_arvalid, bus.axi_awvalid,
                      bus.axi_wvalid}, bus.rsp_rdata, {bus.rsp_resp, bus.rsp_err});
         end
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.axi_arvalid} !== 3'b010) begin
         failures++;
         $display("FAIL stall_release got=%b exp=010",
                  {bus.rsp_valid, bus.cmd_ready, bus.axi_arvalid});
      end
      tick();
      bus.cmd_valid   = 1'b0;
      bus.axi_arready = 1'b1;
      checks++;
      if ({bus.axi_arvalid, bus.cmd_ready, bus.axi_araddr} !== {2'b10, 32'h0000_0080}) begin
         failures++;
         $display("FAIL stall_next_cmd got=%b_%h exp=10_00000080",
                  {bus.axi_arvalid, bus.cmd_ready}, bus.axi_araddr);
      end
      tick();
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b1;
      bus.axi_rdata   = 32'h0000_0055;
      bus.axi_rresp   = 2'b00;
      tick();
      bus.axi_rvalid = 1'b0;
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {1'b1, 32'h0000_0055, 1'b0}) begin
         failures++;
         $display("FAIL stall_next_rsp got=%b_%h_%b exp=1_00000055_0",
                  bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      issue(1'b1, 32'h0000_00F0, 32'hCAFE_BABE, 4'hC);
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready} !== 3'b110) begin
         failures++;
         $display("FAIL rstmid_pre got=%b exp=110",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready,
           bus.rsp_valid, bus.cmd_ready, bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb,
           bus.rsp_rdata} !== {7'b0000001, 100'h0}) begin
         failures++;
         $display("FAIL rstmid_out got=%b_%h_%h_%h_%h exp=0000001_0_0_0_0",
                  {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid,
                   bus.axi_rready, bus.rsp_valid, bus.cmd_ready}, bus.axi_awaddr,
                  bus.axi_wdata, bus.axi_wstrb, bus.rsp_rdata);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.cmd_ready, bus.axi_awvalid, bus.axi_wvalid} !== 3'b100) begin
         failures++;
         $display("FAIL rstmid_post got=%b exp=100",
                  {bus.cmd_ready, bus.axi_awvalid, bus.axi_wvalid});
      end
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst             = 1'b0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_we      = 1'b0;
      bus.cmd_addr    = 32'h0;
      bus.cmd_wdata   = 32'h0;
      bus.cmd_wstrb   = 4'h0;
      bus.rsp_ready   = 1'b0;
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bresp   = 2'b00;
      bus.axi_bvalid  = 1'b0;
      bus.axi_arready = 1'b0;
      bus.axi_rdata   = 32'h0;
      bus.axi_rresp   = 2'b00;
      bus.axi_rvalid  = 1'b0;

      test_reset();
      test_read_delayed();
      test_write_basic();
      test_write_w_first();
      test_read_err();
      test_rsp_stall();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
